// File: rtl/fifo_write_unit.sv
// Write-side pointer and flag controller for the FIFO.
// Owns the wrap+index write pointer and derives full/level flags against rd_ptr.
module fifo_write_unit #(
    parameter int S        = 8,
    parameter int DEPTH    = 90,
    parameter int AF_LEVEL = 80
) (
    input  logic         wr_clk,
    input  logic         wr_rst_n,
    input  logic         wr_en,
    input  logic         ovf_clr,
    input  logic [S-1:0] rd_ptr,
    output logic [S-1:0] wr_ptr,
    output logic         mem_we,
    output logic [S-2:0] mem_waddr,
    output logic         fifo_full,
    output logic         almost_full,
    output logic [S-1:0] fill_level,
    output logic         overflow
);

    localparam logic [S-2:0] LAST_IDX = (S-1)'(DEPTH - 1);
    localparam logic [S-1:0] DEPTH_W  = S'(DEPTH);
    localparam logic [S-1:0] AF_W     = S'(AF_LEVEL);

    logic [S-1:0] wr_ptr_q, wr_ptr_d;
    logic         ovf_q, ovf_d;

    logic         wr_wrap, rd_wrap;
    logic [S-2:0] wr_idx, rd_idx;
    logic [S-1:0] wr_ext, rd_ext;
    logic         accept;

    always_comb begin
        wr_wrap = wr_ptr_q[S-1];
        rd_wrap = rd_ptr[S-1];
        wr_idx  = wr_ptr_q[S-2:0];
        rd_idx  = rd_ptr[S-2:0];
        wr_ext  = {1'b0, wr_idx};
        rd_ext  = {1'b0, rd_idx};
    end

    // Level and full both come straight from the two pointers.
    always_comb begin
        fifo_full = (wr_wrap != rd_wrap) && (wr_idx == rd_idx);
        if (wr_wrap == rd_wrap) begin
            fill_level = wr_ext - rd_ext;
        end else begin
            fill_level = DEPTH_W - rd_ext + wr_ext;
        end
        almost_full = (fill_level >= AF_W);
        accept      = wr_en && !fifo_full;
        mem_we      = accept;
        mem_waddr   = wr_idx;
        wr_ptr      = wr_ptr_q;
        overflow    = ovf_q;
    end

    // Index wraps at DEPTH-1, not at the power-of-two boundary.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        if (accept) begin
            if (wr_idx == LAST_IDX) begin
                wr_ptr_d = {~wr_wrap, {(S-1){1'b0}}};
            end else begin
                wr_ptr_d = {wr_wrap, wr_idx + 1'b1};
            end
        end
    end

    always_comb begin
        ovf_d = ovf_q;
        if (wr_en && fifo_full) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n) begin
            wr_ptr_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            ovf_q    <= ovf_d;
        end
    end

endmodule
